// File: rtl/f_pc_gen_if.sv
// Fetch-side bundle between the PC generator and its pipeline/memory neighbours.
// The slave modport is the PC generator; the master modport drives control and redirects.
interface f_pc_gen_if #(
    parameter int WIDTH = 32
);
  logic             en;
  logic             req_ready;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             exc_valid;
  logic             eret_valid;
  logic [WIDTH-1:0] epc_in;
  logic [WIDTH-1:0] pc;
  logic             req_valid;
  logic             pend;
  logic             pc_misalign;

  modport master (
    output en, req_ready, br_valid, br_target, exc_valid, eret_valid, epc_in,
    input  pc, req_valid, pend, pc_misalign
  );

  modport slave (
    input  en, req_ready, br_valid, br_target, exc_valid, eret_valid, epc_in,
    output pc, req_valid, pend, pc_misalign
  );
endinterface

// File: rtl/f_pc_gen.sv
// Fetch PC generator: BOOT/RUN/PEND FSM with exception, eret and branch redirects.
// Optional F_PC_MISALIGN_TRAP_EN turns misaligned redirect targets into an EXC_PC trap.
module f_pc_gen #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
    parameter int               STEP     = 4
) (
    input  logic          clk,
    input  logic          reset,
    f_pc_gen_if.slave     bus
);
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pend_tgt;
  logic             r_req_valid;
  logic             r_pend;

  logic             w_adv;
  logic             w_do_redir;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_load;
  logic             w_trap;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] t);
    return |t[1:0];
  endfunction

  assign w_adv = bus.en & r_req_valid & bus.req_ready;

  // eret beats branch beats pending; exception is handled ahead of all of these in the FSM
  always_comb begin
    w_tgt      = r_pend_tgt;
    w_do_redir = 1'b0;
    if (bus.eret_valid) begin
      w_tgt      = bus.epc_in;
      w_do_redir = 1'b1;
    end else if (bus.br_valid && w_adv) begin
      w_tgt      = bus.br_target;
      w_do_redir = 1'b1;
    end else if ((r_state == S_PEND) && w_adv) begin
      w_tgt      = r_pend_tgt;
      w_do_redir = 1'b1;
    end else begin
      w_do_redir = 1'b0;
    end
  end

`ifdef F_PC_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_tgt);
  assign w_load = w_trap ? EXC_PC : w_tgt;
`else
  assign w_trap = 1'b0;
  assign w_load = w_tgt & ALIGN_MASK;
`endif

`ifdef F_PC_MISALIGN_TRAP_EN
  logic r_misalign;

  // one-cycle trap pulse, only when a redirect actually loads (exception overrides it)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_trap & w_do_redir & ~bus.exc_valid;
    end
  end

  assign bus.pc_misalign = r_misalign;
`else
  assign bus.pc_misalign = 1'b0;
`endif

  // PC/state FSM; a branch that cannot advance is parked in r_pend_tgt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_pend_tgt  <= '0;
      r_req_valid <= 1'b0;
      r_pend      <= 1'b0;
    end else if (bus.exc_valid) begin
      r_pc        <= EXC_PC;
      r_pend_tgt  <= '0;
      r_state     <= S_RUN;
      r_req_valid <= 1'b1;
      r_pend      <= 1'b0;
    end else if (w_do_redir) begin
      r_pc        <= w_load;
      r_pend_tgt  <= '0;
      r_state     <= S_RUN;
      r_req_valid <= 1'b1;
      r_pend      <= 1'b0;
    end else if (bus.br_valid) begin
      r_pend_tgt  <= bus.br_target;
      r_state     <= S_PEND;
      r_req_valid <= 1'b1;
      r_pend      <= 1'b1;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state     <= S_RUN;
          r_req_valid <= 1'b1;
          r_pend      <= 1'b0;
        end
        S_RUN: begin
          if (w_adv) begin
            r_pc <= r_pc + STEP_W;
          end else begin
            r_pc <= r_pc;
          end
        end
        S_PEND: begin
          r_pc <= r_pc;
        end
        default: begin
          r_state     <= S_BOOT;
          r_req_valid <= 1'b0;
          r_pend      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.req_valid = r_req_valid;
  assign bus.pend      = r_pend;

  logic w_unused;
  assign w_unused = w_trap;
endmodule

// File: doc/f_pc_gen.md
F_PC_GEN -- requirements
Module: f_pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, PC width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-003 Parameter EXC_PC, default 32'h0000_4180, exception handler entry.
REQ-004 Parameter STEP, default 4, sequential increment.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 en  input  1  stall control; 0 = hold PC (pipeline stall).
REQ-008 req_ready  input  1  instruction memory accepts current PC.
REQ-009 br_valid  input  1  branch/jump redirect request.
REQ-010 br_target  input  WIDTH  branch/jump target.
REQ-011 exc_valid  input  1  exception flush request.
REQ-012 eret_valid  input  1  return-from-exception request.
REQ-013 epc_in  input  WIDTH  return address for eret.
REQ-014 pc  output  WIDTH  current fetch address.
REQ-015 req_valid  output  1  pc is a valid fetch request.
REQ-016 pend  output  1  a branch redirect is held pending.
REQ-017 pc_misalign  output  1  one-cycle pulse on misaligned redirect trap.

Function
REQ-018 States SHALL be BOOT, RUN, PEND; req_valid = 0 in BOOT, 1 in RUN and PEND.
REQ-019 BOOT SHALL last exactly one cycle after reset release, then go to RUN with pc = RESET_PC unchanged.
REQ-020 Advance adv = en & req_valid & req_ready; pc SHALL change only on adv or flush (REQ-022/023).
REQ-021 Sequential next PC SHALL be pc + STEP modulo 2^WIDTH (wraps to 0, no flag).
REQ-022 exc_valid SHALL load EXC_PC next cycle regardless of en/req_ready, clear pending, state RUN.
REQ-023 eret_valid (exc_valid low) SHALL load epc_in next cycle regardless of en/req_ready, clear pending, state RUN.
REQ-024 br_valid with adv (no exc/eret) SHALL load br_target next cycle; with no adv SHALL latch br_target into pending register, state PEND.
REQ-025 In PEND, a new br_valid SHALL overwrite pending target; first adv SHALL load pending target (or br_target if br_valid same cycle) and return to RUN.
REQ-026 Priority SHALL be exc_valid > eret_valid > br_valid > pending > sequential.
REQ-027 Redirect latency SHALL be one cycle: target visible on pc the cycle after the request edge.
REQ-028 Requests arriving in BOOT: exc/eret SHALL apply; br SHALL be pended.
REQ-029 pend SHALL equal (state == PEND).

Reset
REQ-030 reset low SHALL immediately force pc = RESET_PC, req_valid = 0, pend = 0, pc_misalign = 0, pending target = 0, state BOOT.
REQ-031 Reset asserted mid-PEND SHALL discard the pending redirect.
REQ-032 No initial blocks; reset is the only initialisation.

Configuration
REQ-033 Macro F_PC_MISALIGN_TRAP_EN: when defined, a redirect target (br, pending, eret) with nonzero bits [1:0] SHALL load EXC_PC instead and pulse pc_misalign for one cycle.
REQ-034 Without F_PC_MISALIGN_TRAP_EN, redirect targets SHALL have bits [1:0] forced to 0 and pc_misalign SHALL be tied 0.

Verification
REQ-035 Release reset, en=1, req_ready=1 -> pc 0x3000 for 2 cycles (BOOT then RUN), then 0x3004, 0x3008; req_valid 0 then 1.
REQ-036 RUN, en=0, br_valid=1 target 0x3100 for one cycle -> pend=1, pc holds; en=1 -> pc 0x3100 next cycle, pend=0.
REQ-037 PEND with target 0x3100, exc_valid=1, en=0 -> pc 0x4180 next cycle, pend=0; later adv -> 0x4184 (pending discarded).
REQ-038 WIDTH=8, RESET_PC=8'hFC, STEP=4 -> after BOOT, adv gives 0xFC -> 0x00 wrap.
REQ-039 br_target 0x3102 with adv -> macro defined: pc 0x4180, pc_misalign pulse 1 cycle; undefined: pc 0x3100, pc_misalign 0.
REQ-040 Assert reset low asynchronously mid-cycle in PEND -> pc 0x3000, req_valid 0, pend 0 without waiting for clk edge.
